// File: rtl/onchip_memory_dp_arb.sv
// Dual Avalon-MM slave RAM: two ports round-robin arbitrated onto one single-port array, pipelined reads.
// Optional OCM_ADDR_ERR_EN adds sN_response (SLVERR on out-of-range reads) and a sticky addr_err output.
module onchip_memory_dp_arb #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 17,
   parameter int DEPTH        = 102400,
   parameter int READ_LATENCY = 1,
   parameter     INIT_FILE    = ""
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clken,
   input  logic                      reset_req,
   input  logic [ADDR_WIDTH-1:0]     s1_address,
   input  logic [DATA_WIDTH/8-1:0]   s1_byteenable,
   input  logic                      s1_chipselect,
   input  logic                      s1_read,
   input  logic                      s1_write,
   input  logic [DATA_WIDTH-1:0]     s1_writedata,
   output logic [DATA_WIDTH-1:0]     s1_readdata,
   output logic                      s1_readdatavalid,
   output logic                      s1_waitrequest,
   input  logic [ADDR_WIDTH-1:0]     s2_address,
   input  logic [DATA_WIDTH/8-1:0]   s2_byteenable,
   input  logic                      s2_chipselect,
   input  logic                      s2_read,
   input  logic                      s2_write,
   input  logic [DATA_WIDTH-1:0]     s2_writedata,
   output logic [DATA_WIDTH-1:0]     s2_readdata,
   output logic                      s2_readdatavalid,
`ifdef OCM_ADDR_ERR_EN
   output logic [1:0]                s1_response,
   output logic [1:0]                s2_response,
   output logic                      addr_err,
`endif
   output logic                      s2_waitrequest
);

   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

   logic                  en, s1_req, s2_req, grant1, grant2, acc;
   logic                  sel_port, sel_wr, in_range, mem_wr_en, mem_rd_en;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [BE_W-1:0]       sel_be;
   logic [DATA_WIDTH-1:0] sel_wd;
   logic [IDX_W-1:0]      idx;
   logic                  last_grant_q, last_grant_d;
   logic                  rd_v_a_q, rd_v_a_d, rd_p_a_q, rd_p_a_d;
   logic [DATA_WIDTH-1:0] rd_word_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef OCM_ADDR_ERR_EN
   logic                  rd_e_a_q, rd_e_a_d, addr_err_q, addr_err_d;
`endif

   // last_grant_q: 0 = s1 was last served, 1 = s2; on a conflict the other port wins
   always_comb begin
      en             = clken & ~reset_req;
      s1_req         = s1_chipselect & (s1_read | s1_write);
      s2_req         = s2_chipselect & (s2_read | s2_write);
      grant1         = s1_req & (~s2_req | last_grant_q);
      grant2         = s2_req & ~grant1;
      s1_waitrequest = s1_req & (~grant1 | ~en);
      s2_waitrequest = s2_req & (~grant2 | ~en);
      acc            = (grant1 | grant2) & en;
      sel_port       = grant2;
      sel_addr       = grant2 ? s2_address    : s1_address;
      sel_wr         = grant2 ? s2_write      : s1_write;
      sel_be         = grant2 ? s2_byteenable : s1_byteenable;
      sel_wd         = grant2 ? s2_writedata  : s1_writedata;
      idx            = sel_addr[IDX_W-1:0];
      in_range       = {1'b0, sel_addr} < DEPTH_W;
      mem_wr_en      = ~reset & acc & sel_wr & in_range;
      mem_rd_en      = ~reset & acc & ~sel_wr;
      last_grant_d   = acc ? sel_port : last_grant_q;
      rd_v_a_d       = acc & ~sel_wr;
      rd_p_a_d       = sel_port;
`ifdef OCM_ADDR_ERR_EN
      rd_e_a_d       = ~in_range;
      addr_err_d     = addr_err_q | (acc & ~in_range);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         rd_v_a_q     <= 1'b0;
         rd_p_a_q     <= 1'b0;
`ifdef OCM_ADDR_ERR_EN
         rd_e_a_q     <= 1'b0;
         addr_err_q   <= 1'b0;
`endif
      end else if (en) begin
         last_grant_q <= last_grant_d;
         rd_v_a_q     <= rd_v_a_d;
         rd_p_a_q     <= rd_p_a_d;
`ifdef OCM_ADDR_ERR_EN
         rd_e_a_q     <= rd_e_a_d;
         addr_err_q   <= addr_err_d;
`endif
      end
   end

   // Array is never reset; a read the cycle after a write naturally sees the new word
   always_ff @(posedge clk) begin
      for (int i = 0; i < BE_W; i++)
         if (mem_wr_en && sel_be[i]) mem[idx][i*8 +: 8] <= sel_wd[i*8 +: 8];
      if (mem_rd_en) rd_word_q <= in_range ? mem[idx] : '0;
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic                  rd_v_b_q, rd_p_b_q;
      logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d, s2_data_q, s2_data_d;
`ifdef OCM_ADDR_ERR_EN
      logic                  rd_e_b_q;
`endif

      always_comb begin
         s1_data_d = s1_data_q;
         s2_data_d = s2_data_q;
         if (rd_v_a_q && !rd_p_a_q) s1_data_d = rd_word_q;
         if (rd_v_a_q &&  rd_p_a_q) s2_data_d = rd_word_q;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            rd_v_b_q  <= 1'b0;
            rd_p_b_q  <= 1'b0;
            s1_data_q <= '0;
            s2_data_q <= '0;
`ifdef OCM_ADDR_ERR_EN
            rd_e_b_q  <= 1'b0;
`endif
         end else if (en) begin
            rd_v_b_q  <= rd_v_a_q;
            rd_p_b_q  <= rd_p_a_q;
            s1_data_q <= s1_data_d;
            s2_data_q <= s2_data_d;
`ifdef OCM_ADDR_ERR_EN
            rd_e_b_q  <= rd_e_a_q;
`endif
         end
      end

      assign s1_readdatavalid = rd_v_b_q & ~rd_p_b_q;
      assign s2_readdatavalid = rd_v_b_q &  rd_p_b_q;
      assign s1_readdata      = s1_data_q;
      assign s2_readdata      = s2_data_q;
`ifdef OCM_ADDR_ERR_EN
      assign s1_response      = (s1_readdatavalid & rd_e_b_q) ? 2'b10 : 2'b00;
      assign s2_response      = (s2_readdatavalid & rd_e_b_q) ? 2'b10 : 2'b00;
`endif
   end else begin : g_lat1
      // Memory output register drives the port while valid; hold regs keep the last word afterwards
      logic [DATA_WIDTH-1:0] s1_hold_q, s1_hold_d, s2_hold_q, s2_hold_d;
      logic                  v1, v2;

      always_comb begin
         v1        = rd_v_a_q & ~rd_p_a_q;
         v2        = rd_v_a_q &  rd_p_a_q;
         s1_hold_d = v1 ? rd_word_q : s1_hold_q;
         s2_hold_d = v2 ? rd_word_q : s2_hold_q;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            s1_hold_q <= '0;
            s2_hold_q <= '0;
         end else if (en) begin
            s1_hold_q <= s1_hold_d;
            s2_hold_q <= s2_hold_d;
         end
      end

      assign s1_readdatavalid = v1;
      assign s2_readdatavalid = v2;
      assign s1_readdata      = v1 ? rd_word_q : s1_hold_q;
      assign s2_readdata      = v2 ? rd_word_q : s2_hold_q;
`ifdef OCM_ADDR_ERR_EN
      assign s1_response      = (v1 & rd_e_a_q) ? 2'b10 : 2'b00;
      assign s2_response      = (v2 & rd_e_a_q) ? 2'b10 : 2'b00;
`endif
   end

`ifdef OCM_ADDR_ERR_EN
   assign addr_err = addr_err_q;
`endif

endmodule

// File: tb/tb_onchip_memory_dp_arb.sv
// Bench for onchip_memory_dp_arb: latency-1 and latency-2 instances share one stimulus stream
// and are checked against a transaction-level model of the arbitrated memory.
module tb_onchip_memory_dp_arb;

   localparam int DW    = 32;
   localparam int AW    = 17;
   localparam int DEPTH = 102400;

   logic          clk = 1'b0;
   logic          reset, clken, reset_req;
   logic [AW-1:0] s1_address, s2_address;
   logic [3:0]    s1_byteenable, s2_byteenable;
   logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
   logic [DW-1:0] s1_writedata, s2_writedata;
   logic [DW-1:0] a_s1_rdata, a_s2_rdata, b_s1_rdata, b_s2_rdata;
   logic          a_s1_rdv, a_s2_rdv, b_s1_rdv, b_s2_rdv;
   logic          a_s1_wait, a_s2_wait, b_s1_wait, b_s2_wait;
`ifdef OCM_ADDR_ERR_EN
   logic [1:0]    a_s1_resp, a_s2_resp, b_s1_resp, b_s2_resp;
   logic          a_aerr, b_aerr;
   logic [1:0]    obs_r [1:2][1:2];
   logic [1:0]    exp_r [1:2][1:2];
   bit            slot_e [int];
`endif

   always #5 clk = ~clk;

   onchip_memory_dp_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1)) u_lat1 (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
      .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
      .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
      .s1_readdata(a_s1_rdata), .s1_readdatavalid(a_s1_rdv), .s1_waitrequest(a_s1_wait),
      .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
      .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
      .s2_readdata(a_s2_rdata), .s2_readdatavalid(a_s2_rdv),
`ifdef OCM_ADDR_ERR_EN
      .s1_response(a_s1_resp), .s2_response(a_s2_resp), .addr_err(a_aerr),
`endif
      .s2_waitrequest(a_s2_wait));

   onchip_memory_dp_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2)) u_lat2 (
      .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
      .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
      .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
      .s1_readdata(b_s1_rdata), .s1_readdatavalid(b_s1_rdv), .s1_waitrequest(b_s1_wait),
      .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
      .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
      .s2_readdata(b_s2_rdata), .s2_readdatavalid(b_s2_rdv),
`ifdef OCM_ADDR_ERR_EN
      .s1_response(b_s1_resp), .s2_response(b_s2_resp), .addr_err(b_aerr),
`endif
      .s2_waitrequest(b_s2_wait));

   // Observed outputs indexed [latency][port]
   logic          obs_v [1:2][1:2];
   logic [DW-1:0] obs_d [1:2][1:2];
   logic          obs_w [1:2][1:2];

   always_comb begin
      obs_v[1][1] = a_s1_rdv;   obs_v[1][2] = a_s2_rdv;
      obs_v[2][1] = b_s1_rdv;   obs_v[2][2] = b_s2_rdv;
      obs_d[1][1] = a_s1_rdata; obs_d[1][2] = a_s2_rdata;
      obs_d[2][1] = b_s1_rdata; obs_d[2][2] = b_s2_rdata;
`ifdef OCM_ADDR_ERR_EN
      obs_r[1][1] = a_s1_resp;  obs_r[1][2] = a_s2_resp;
      obs_r[2][1] = b_s1_resp;  obs_r[2][2] = b_s2_resp;
`endif
   end

   // Reference model: word memory, enabled-cycle slot log of reads, last served port
   logic [DW-1:0] mmem [int];
   bit            slot_v [int];
   int            slot_p [int];
   logic [DW-1:0] slot_d [int];
   int            en_cnt = 0, reset_base = 0, last_port = 2, last_win = 0;
   logic          exp_v [1:2][1:2];
   logic [DW-1:0] exp_d [1:2][1:2];
   logic          exp_w [1:2];
   logic          exp_aerr = 1'b0;
   int            total = 0, bad = 0;

   task automatic clear_ports();
      s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_writedata = '0; s1_byteenable = '0;
      s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_writedata = '0; s2_byteenable = '0;
   endtask

   task automatic set_port(input int p, input bit cs, input bit rd, input bit wr, input int addr,
                           input logic [DW-1:0] wd, input logic [3:0] be);
      if (p == 1) begin
         s1_chipselect = cs; s1_read = rd; s1_write = wr; s1_address = AW'(addr);
         s1_writedata = wd; s1_byteenable = be;
      end else begin
         s2_chipselect = cs; s2_read = rd; s2_write = wr; s2_address = AW'(addr);
         s2_writedata = wd; s2_byteenable = be;
      end
   endtask

   // Advance one clock: predict waitrequest, apply the transaction to the model, then predict outputs
   task automatic tick();
      bit            en, q1, q2, isw, oor;
      int            win, a, k;
      logic [DW-1:0] wd, word;
      logic [3:0]    be;
      #1;
      en = clken && !reset_req;
      q1 = s1_chipselect && (s1_read || s1_write);
      q2 = s2_chipselect && (s2_read || s2_write);
      win = 0;
      if (q1 && q2) win = (last_port == 2) ? 1 : 2;
      else if (q1)  win = 1;
      else if (q2)  win = 2;
      exp_w[1] = q1 && (win != 1 || !en);
      exp_w[2] = q2 && (win != 2 || !en);
      obs_w[1][1] = a_s1_wait; obs_w[1][2] = a_s2_wait;
      obs_w[2][1] = b_s1_wait; obs_w[2][2] = b_s2_wait;
      last_win = 0;
      if (reset) begin
         last_port  = 2;
         reset_base = en_cnt;
         exp_aerr   = 1'b0;
         for (int l = 1; l <= 2; l++) for (int p = 1; p <= 2; p++) exp_d[l][p] = '0;
      end else if (en) begin
         slot_v[en_cnt] = 0;
         if (win != 0) begin
            last_win  = win;
            last_port = win;
            a   = (win == 1) ? int'(s1_address) : int'(s2_address);
            isw = (win == 1) ? s1_write : s2_write;
            wd  = (win == 1) ? s1_writedata : s2_writedata;
            be  = (win == 1) ? s1_byteenable : s2_byteenable;
            oor = (a >= DEPTH);
            if (oor) exp_aerr = 1'b1;
            word = mmem.exists(a) ? mmem[a] : '0;
            if (isw) begin
               if (!oor) begin
                  for (int i = 0; i < 4; i++) if (be[i]) word[i*8 +: 8] = wd[i*8 +: 8];
                  mmem[a] = word;
               end
            end else begin
               slot_v[en_cnt] = 1;
               slot_p[en_cnt] = win;
               slot_d[en_cnt] = oor ? '0 : word;
`ifdef OCM_ADDR_ERR_EN
               slot_e[en_cnt] = oor;
`endif
            end
         end
         en_cnt++;
      end
      @(posedge clk);
      #1;
      for (int l = 1; l <= 2; l++) begin
         k = en_cnt - l;
         exp_v[l][1] = 0; exp_v[l][2] = 0;
`ifdef OCM_ADDR_ERR_EN
         exp_r[l][1] = 2'b00; exp_r[l][2] = 2'b00;
`endif
         if (k >= reset_base && slot_v.exists(k) && slot_v[k]) begin
            exp_v[l][slot_p[k]] = 1;
            exp_d[l][slot_p[k]] = slot_d[k];
`ifdef OCM_ADDR_ERR_EN
            exp_r[l][slot_p[k]] = slot_e[k] ? 2'b10 : 2'b00;
`endif
         end
      end
   endtask

   task automatic test_reset();
      reset = 1; clken = 1; reset_req = 0;
      clear_ports();
      for (int c = 0; c < 2; c++) begin
         tick();
         for (int l = 1; l <= 2; l++) for (int p = 1; p <= 2; p++) begin
            total++;
            if (obs_w[l][p] !== exp_w[p] || obs_v[l][p] !== exp_v[l][p] || obs_d[l][p] !== exp_d[l][p]) begin
               bad++;
               $display("[TB] FAIL reset c%0d L%0d s%0d: got w=%b v=%b d=%h, need w=%b v=%b d=%h",
                        c, l, p, obs_w[l][p], obs_v[l][p], obs_d[l][p], exp_w[p], exp_v[l][p], exp_d[l][p]);
            end
         end
      end
`ifdef OCM_ADDR_ERR_EN
      total++;
      if (a_aerr !== 1'b0 || b_aerr !== 1'b0) begin
         bad++; $display("[TB] FAIL reset addr_err: got %b/%b, need 0", a_aerr, b_aerr);
      end
`endif
      reset = 0;
   endtask

   task automatic test_write_read();
      for (int c = 0; c < 5; c++) begin
         clear_ports();
         case (c)
            0: set_port(1, 1, 0, 1, 'h10, 32'hDEADBEEF, 4'hF);
            1: set_port(1, 1, 1, 0, 'h10, '0, 4'h0);
            default: ;
         endcase
         tick();
         for (int l = 1; l <= 2; l++) for (int p = 1; p <= 2; p++) begin
            total++;
            if (obs_w[l][p] !== exp_w[p] || obs_v[l][p] !== exp_v[l][p] || obs_d[l][p] !== exp_d[l][p]) begin
               bad++;
               $display("[TB] FAIL write_read c%0d L%0d s%0d: got w=%b v=%b d=%h, need w=%b v=%b d=%h",
                        c, l, p, obs_w[l][p], obs_v[l][p], obs_d[l][p], exp_w[p], exp_v[l][p], exp_d[l][p]);
            end
         end
         if (c == 1) begin
            total++;
            if (a_s1_rdv !== 1'b1 || a_s1_rdata !== 32'hDEADBEEF || a_s2_rdv !== 1'b0) begin
               bad++;
               $display("[TB] FAIL write_read lat1: got v=%b d=%h s2v=%b, need 1 deadbeef 0", a_s1_rdv, a_s1_rdata, a_s2_rdv);
            end
         end
      end
   endtask

   task automatic test_byteenable();
      for (int c = 0; c < 4; c++) begin
         clear_ports();
         case (c)
            0: set_port(1, 1, 0, 1, 'h11, 32'hFFFFFFFF, 4'hF);
            1: set_port(2, 1, 0, 1, 'h11, 32'h00000000, 4'b0101);
            2: set_port(1, 1, 1, 0, 'h11, '0, 4'h0);
            default: ;
         endcase
         tick();
         for (int l = 1; l <= 2; l++) for (int p = 1; p <= 2; p++) begin
            total++;
            if (obs_w[l][p] !== exp_w[p] || obs_v[l][p] !== exp_v[l][p] || obs_d[l][p] !== exp_d[l][p]) begin
               bad++;
               $display("[TB] FAIL byteenable c%0d L%0d s%0d: got w=%b v=%b d=%h, need w=%b v=%b d=%h",
                        c, l, p, obs_w[l][p], obs_v[l][p], obs_d[l][p], exp_w[p], exp_v[l][p], exp_d[l][p]);
            end
         end
         if (c == 2) begin
            total++;
            if (a_s1_rdv !== 1'b1 || a_s1_rdata !== 32'hFF00FF00) begin
               bad++; $display("[TB] FAIL byteenable word: got v=%b d=%h, need 1 ff00ff00", a_s1_rdv, a_s1_rdata);
            end
         end
      end
   endtask

   task automatic test_alternate();
      int n1 = 0, n2 = 0, cnt1 = 0, cnt2 = 0;
      for (int i = 0; i < 6; i++) begin
         clear_ports();
         set_port(1, 1, 0, 1, 'h20 + i, 32'hA5000000 + i, 4'hF);
         set_port(2, 1, 0, 1, 'h28 + i, 32'h5A000000 + i, 4'hF);
         tick();
         clear_ports();
         tick();
      end
      reset = 1; clear_ports(); tick(); reset = 0;
      for (int c = 0; c < 8; c++) begin
         clear_ports();
         if (c < 6) begin
            set_port(1, 1, 1, 0, 'h20 + n1, '0, 4'h0);
            set_port(2, 1, 1, 0, 'h28 + n2, '0, 4'h0);
         end
         tick();
         if (last_win == 1) n1++;
         if (last_win == 2) n2++;
         cnt1 += int'(a_s1_rdv);
         cnt2 += int'(a_s2_rdv);
         for (int l = 1; l <= 2; l++) for (int p = 1; p <= 2; p++) begin
            total++;
            if (obs_w[l][p] !== exp_w[p] || obs_v[l][p] !== exp_v[l][p] || obs_d[l][p] !== exp_d[l][p]) begin
               bad++;
               $display("[TB] FAIL alternate c%0d L%0d s%0d: got w=%b v=%b d=%h, need w=%b v=%b d=%h",
                        c, l, p, obs_w[l][p], obs_v[l][p], obs_d[l][p], exp_w[p], exp_v[l][p], exp_d[l][p]);
            end
         end
         if (c < 6) begin
            total++;
            if (obs_w[1][1] !== logic'(c % 2 == 1) || obs_w[1][2] !== logic'(c % 2 == 0)) begin
               bad++;
               $display("[TB] FAIL alternate wait c%0d: got s1=%b s2=%b, need s1=%0d s2=%0d",
                        c, obs_w[1][1], obs_w[1][2], c % 2, 1 - c % 2);
            end
         end
      end
      total++;
      if (cnt1 != 3 || cnt2 != 3) begin
         bad++; $display("[TB] FAIL alternate valid count: got %0d/%0d, need 3/3", cnt1, cnt2);
      end
   endtask

   task automatic test_stall();
      int cnt = 0;
      for (int c = 0; c < 8; c++) begin
         clear_ports();
         clken = 1; reset_req = 0;
         case (c)
            0: set_port(1, 1, 1, 0, 'h10, '0, 4'h0);
            1: clken = 0;
            2: begin clken = 0; set_port(2, 1, 1, 0, 'h11, '0, 4'h0); end
            3: reset_req = 1;
            default: ;
         endcase
         tick();
         cnt += int'(b_s1_rdv);
         for (int l = 1; l <= 2; l++) for (int p = 1; p <= 2; p++) begin
            total++;
            if (obs_w[l][p] !== exp_w[p] || obs_v[l][p] !== exp_v[l][p] || obs_d[l][p] !== exp_d[l][p]) begin
               bad++;
               $display("[TB] FAIL stall c%0d L%0d s%0d: got w=%b v=%b d=%h, need w=%b v=%b d=%h",
                        c, l, p, obs_w[l][p], obs_v[l][p], obs_d[l][p], exp_w[p], exp_v[l][p], exp_d[l][p]);
            end
         end
         if (c == 4) begin
            total++;
            if (b_s1_rdv !== 1'b1 || b_s1_rdata !== 32'hDEADBEEF) begin
               bad++; $display("[TB] FAIL stall lat2 valid: got v=%b d=%h, need 1 deadbeef", b_s1_rdv, b_s1_rdata);
            end
         end
      end
      clken = 1; reset_req = 0;
      total++;
      if (cnt != 1) begin
         bad++; $display("[TB] FAIL stall lat2 pulses: got %0d, need 1", cnt);
      end
   endtask

   task automatic test_reset_inflight();
      int cnt = 0;
      for (int c = 0; c < 6; c++) begin
         clear_ports();
         reset = (c == 1);
         if (c == 0 || c == 3) set_port(1, 1, 1, 0, 'h10, '0, 4'h0);
         tick();
         if (c < 3) cnt += int'(b_s1_rdv);
         for (int l = 1; l <= 2; l++) for (int p = 1; p <= 2; p++) begin
            total++;
            if (obs_w[l][p] !== exp_w[p] || obs_v[l][p] !== exp_v[l][p] || obs_d[l][p] !== exp_d[l][p]) begin
               bad++;
               $display("[TB] FAIL reset_inflight c%0d L%0d s%0d: got w=%b v=%b d=%h, need w=%b v=%b d=%h",
                        c, l, p, obs_w[l][p], obs_v[l][p], obs_d[l][p], exp_w[p], exp_v[l][p], exp_d[l][p]);
            end
         end
         if (c == 4) begin
            total++;
            if (b_s1_rdv !== 1'b1 || b_s1_rdata !== 32'hDEADBEEF) begin
               bad++; $display("[TB] FAIL reset_inflight reread: got v=%b d=%h, need 1 deadbeef", b_s1_rdv, b_s1_rdata);
            end
         end
      end
      reset = 0;
      total++;
      if (cnt != 0) begin
         bad++; $display("[TB] FAIL reset_inflight dropped read: got %0d lat2 pulses, need 0", cnt);
      end
   endtask

   task automatic test_addr_err();
      for (int c = 0; c < 6; c++) begin
         clear_ports();
         reset = (c == 4);
         case (c)
            0: set_port(2, 1, 1, 0, DEPTH, '0, 4'h0);
            1: set_port(1, 1, 0, 1, DEPTH + 1, 32'h12345678, 4'hF);
            default: ;
         endcase
         tick();
         for (int l = 1; l <= 2; l++) for (int p = 1; p <= 2; p++) begin
            total++;
            if (obs_w[l][p] !== exp_w[p] || obs_v[l][p] !== exp_v[l][p] || obs_d[l][p] !== exp_d[l][p]) begin
               bad++;
               $display("[TB] FAIL addr_err c%0d L%0d s%0d: got w=%b v=%b d=%h, need w=%b v=%b d=%h",
                        c, l, p, obs_w[l][p], obs_v[l][p], obs_d[l][p], exp_w[p], exp_v[l][p], exp_d[l][p]);
            end
         end
         if (c == 0) begin
            total++;
            if (a_s2_rdv !== 1'b1 || a_s2_rdata !== 32'h0) begin
               bad++; $display("[TB] FAIL addr_err oor read: got v=%b d=%h, need 1 00000000", a_s2_rdv, a_s2_rdata);
            end
         end
`ifdef OCM_ADDR_ERR_EN
         if (c == 0) begin
            total++;
            if (a_s2_resp !== 2'b10) begin
               bad++; $display("[TB] FAIL addr_err response: got %b, need 10", a_s2_resp);
            end
         end
         total++;
         if (a_aerr !== logic'(c < 4) || b_aerr !== logic'(c < 4)) begin
            bad++; $display("[TB] FAIL addr_err sticky c%0d: got %b/%b, need %0d", c, a_aerr, b_aerr, c < 4);
         end
`endif
      end
      reset = 0;
   endtask

   task automatic test_random();
      int a;
      for (int i = 0; i < 16; i++) begin
         clear_ports();
         set_port(1, 1, 0, 1, 'h20 + i, $urandom, 4'hF);
         tick();
      end
      for (int c = 0; c < 304; c++) begin
         clear_ports();
         reset = 0; clken = 1; reset_req = 0;
         if (c < 300) begin
            clken     = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 14) == 0);
            reset     = ($urandom_range(0, 59) == 0);
            for (int p = 1; p <= 2; p++) begin
               a = ($urandom_range(0, 9) == 0) ? DEPTH + int'($urandom_range(0, 3)) : 'h20 + int'($urandom_range(0, 15));
               set_port(p, $urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                        a, $urandom, 4'($urandom));
            end
         end
         tick();
         for (int l = 1; l <= 2; l++) for (int p = 1; p <= 2; p++) begin
            total++;
            if (obs_w[l][p] !== exp_w[p] || obs_v[l][p] !== exp_v[l][p] || obs_d[l][p] !== exp_d[l][p]) begin
               bad++;
               $display("[TB] FAIL random c%0d L%0d s%0d: got w=%b v=%b d=%h, need w=%b v=%b d=%h",
                        c, l, p, obs_w[l][p], obs_v[l][p], obs_d[l][p], exp_w[p], exp_v[l][p], exp_d[l][p]);
            end
`ifdef OCM_ADDR_ERR_EN
            total++;
            if (obs_r[l][p] !== exp_r[l][p]) begin
               bad++; $display("[TB] FAIL random resp c%0d L%0d s%0d: got %b, need %b", c, l, p, obs_r[l][p], exp_r[l][p]);
            end
`endif
         end
`ifdef OCM_ADDR_ERR_EN
         total++;
         if (a_aerr !== exp_aerr || b_aerr !== exp_aerr) begin
            bad++; $display("[TB] FAIL random addr_err c%0d: got %b/%b, need %b", c, a_aerr, b_aerr, exp_aerr);
         end
`endif
      end
      reset = 0; clken = 1; reset_req = 0;
   endtask

   initial begin
      reset = 1; clken = 1; reset_req = 0;
      clear_ports();
      test_reset();
      test_write_read();
      test_byteenable();
      test_alternate();
      test_stall();
      test_reset_inflight();
      test_addr_err();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
